// File: rtl/ahb_master_cmd.sv
// ahb_master_cmd: AHB bus-master front end.
//
// Takes one command at a time (SINGLE or INCR4, read or write) from a local
// client over valid/ready. It then runs the request/grant handshake and drives
// the pipelined AHB address and data phases. Read data and completion status
// are returned to the client.
//
// Ports
//   H_clk, H_resetn            bus clock, async active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake
//   cmd_write_i, cmd_lock_i    direction, locked transfer
//   cmd_burst_i                3'b011 = INCR4, anything else = SINGLE
//   cmd_addr_i, cmd_wdata_i    start address, write beats (beat n = [32n+31:32n])
//   hgrant_i, hready_i         arbiter grant, transfer ready
//   hresp_i, hrdata_i          slave response, read data
//   req_o, lock_o, write_o     bus request, lock, direction
//   addr_o, wdata_o, burst_o   address phase, data phase, burst type
//   trans_o                    00 IDLE, 10 NONSEQ, 11 SEQ
//   rdata_o, rvalid_o          captured read data, one pulse per read beat
//   done_o, err_o              completion pulse, sticky error flag
//
// Build option
//   AHB_MASTER_ERR_ABORT_EN    when defined, an ERROR response cancels the
//                              remaining beats of the burst.
//
// State table
//   S_IDLE      | ready for a command
//   S_REQ       | req_o high, waiting for grant with hready
//   S_ADDR      | address phase of current beat (data phase of previous beat)
//   S_LAST_DATA | no address pending, waiting for the final data phase
module ahb_master_cmd #(
  parameter int DATA_W    = 32,
  parameter int BEATS     = 4,
  parameter int ADDR_STEP = 4
) (
  input  logic                    H_clk,
  input  logic                    H_resetn,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic                    cmd_lock_i,
  input  logic [2:0]              cmd_burst_i,
  input  logic [31:0]             cmd_addr_i,
  input  logic [BEATS*DATA_W-1:0] cmd_wdata_i,
  input  logic                    hgrant_i,
  input  logic                    hready_i,
  input  logic [1:0]              hresp_i,
  input  logic [DATA_W-1:0]       hrdata_i,
  output logic                    req_o,
  output logic                    lock_o,
  output logic                    write_o,
  output logic [31:0]             addr_o,
  output logic [DATA_W-1:0]       wdata_o,
  output logic [2:0]              burst_o,
  output logic [1:0]              trans_o,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    rvalid_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] TR_IDLE      = 2'b00;
  localparam logic [1:0] TR_NONSEQ    = 2'b10;
  localparam logic [1:0] TR_SEQ       = 2'b11;
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam logic [1:0] RESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ADDR, S_LAST_DATA} state_t;

  state_t                  state_q, state_d;
  logic                    cmd_write_q, cmd_write_d;
  logic                    cmd_incr_q, cmd_incr_d;
  logic [31:0]             base_q, base_d;
  logic [BEATS*DATA_W-1:0] wbuf_q, wbuf_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic              cmd_ready_d, req_d, lock_d, write_d, rvalid_d, done_d, err_d;
  logic [31:0]       addr_d;
  logic [DATA_W-1:0] wdata_d, rdata_d;
  logic [2:0]        burst_d;
  logic [1:0]        trans_d;
  logic              data_phase, data_done;

  always_ff @(posedge H_clk or negedge H_resetn) begin
    if (!H_resetn) begin
      state_q     <= S_IDLE;
      cmd_write_q <= 1'b0;
      cmd_incr_q  <= 1'b0;
      base_q      <= '0;
      wbuf_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_o <= 1'b0;
      req_o       <= 1'b0;
      lock_o      <= 1'b0;
      write_o     <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= '0;
      burst_o     <= '0;
      trans_o     <= TR_IDLE;
      rdata_o     <= '0;
      rvalid_o    <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_write_q <= cmd_write_d;
      cmd_incr_q  <= cmd_incr_d;
      base_q      <= base_d;
      wbuf_q      <= wbuf_d;
      cnt_q       <= cnt_d;
      cmd_ready_o <= cmd_ready_d;
      req_o       <= req_d;
      lock_o      <= lock_d;
      write_o     <= write_d;
      addr_o      <= addr_d;
      wdata_o     <= wdata_d;
      burst_o     <= burst_d;
      trans_o     <= trans_d;
      rdata_o     <= rdata_d;
      rvalid_o    <= rvalid_d;
      done_o      <= done_d;
      err_o       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_write_d = cmd_write_q;
    cmd_incr_d  = cmd_incr_q;
    base_d      = base_q;
    wbuf_d      = wbuf_q;
    cnt_d       = cnt_q;
    req_d       = req_o;
    lock_d      = lock_o;
    write_d     = write_o;
    addr_d      = addr_o;
    wdata_d     = wdata_o;
    burst_d     = burst_o;
    trans_d     = trans_o;
    rdata_d     = rdata_o;
    rvalid_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = err_o;
    data_phase  = 1'b0;
    data_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          cmd_write_d = cmd_write_i;
          cmd_incr_d  = (cmd_burst_i == BURST_INCR4);
          base_d      = cmd_addr_i;
          wbuf_d      = cmd_wdata_i;
          err_d       = 1'b0;
          req_d       = 1'b1;
          lock_d      = cmd_lock_i;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (hgrant_i && hready_i) begin
          trans_d = TR_NONSEQ;
          addr_d  = base_q;
          write_d = cmd_write_q;
          burst_d = cmd_incr_q ? BURST_INCR4 : BURST_SINGLE;
          cnt_d   = cmd_incr_q ? CNT_W'(BEATS - 1) : '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        // Only the first beat is NONSEQ; from then on an earlier beat is in
        // its data phase while the current address waits.
        data_phase = (trans_o == TR_SEQ);
        if (hready_i) begin
          data_done = data_phase;
          if (cmd_write_q) wdata_d = wbuf_q[DATA_W-1:0];
          wbuf_d = wbuf_q >> DATA_W;
          if (cnt_q != '0) begin
            addr_d  = addr_o + 32'(ADDR_STEP);
            trans_d = TR_SEQ;
            cnt_d   = cnt_q - 1'b1;
          end else begin
            trans_d = TR_IDLE;
            req_d   = 1'b0;
            state_d = S_LAST_DATA;
          end
        end
`ifdef AHB_MASTER_ERR_ABORT_EN
        else if (data_phase && hresp_i == RESP_ERROR) begin
          // First ERROR cycle: drop the pending address and finish the
          // erroring data phase only.
          trans_d = TR_IDLE;
          req_d   = 1'b0;
          state_d = S_LAST_DATA;
        end
`endif
      end
      S_LAST_DATA: begin
        data_phase = 1'b1;
        if (hready_i) begin
          data_done = 1'b1;
          done_d    = 1'b1;
          lock_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (data_phase && hresp_i == RESP_ERROR) err_d = 1'b1;
    if (data_done && !cmd_write_q) begin
      rdata_d  = hrdata_i;
      rvalid_d = 1'b1;
    end
    cmd_ready_d = (state_d == S_IDLE);
  end

endmodule

// File: tb/tb_ahb_master_cmd.sv
module tb_ahb_master_cmd;

  logic         H_clk = 1'b0;
  logic         H_resetn = 1'b1;
  logic         cmd_valid_i = 1'b0;
  logic         cmd_ready_o;
  logic         cmd_write_i = 1'b0;
  logic         cmd_lock_i = 1'b0;
  logic [2:0]   cmd_burst_i = 3'b000;
  logic [31:0]  cmd_addr_i = '0;
  logic [127:0] cmd_wdata_i = '0;
  logic         hgrant_i;
  logic         hready_i;
  logic [1:0]   hresp_i;
  logic [31:0]  hrdata_i;
  logic         req_o, lock_o, write_o, rvalid_o, done_o, err_o;
  logic [31:0]  addr_o, wdata_o, rdata_o;
  logic [2:0]   burst_o;
  logic [1:0]   trans_o;

  ahb_master_cmd dut (
    .H_clk(H_clk), .H_resetn(H_resetn),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_lock_i(cmd_lock_i),
    .cmd_burst_i(cmd_burst_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .hgrant_i(hgrant_i), .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i),
    .req_o(req_o), .lock_o(lock_o), .write_o(write_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .burst_o(burst_o), .trans_o(trans_o),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 H_clk = ~H_clk;

  // Scoreboard queues: expected address beats {trans,write,burst,addr,lock,req},
  // expected write words, expected read words, expected err_o at each done.
  logic [39:0] aq[$];
  logic [31:0] wq[$];
  logic [31:0] rdq[$];
  logic        dq[$];

  int checks = 0;
  int errors = 0;
  int err_beat_cur = -1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Bus slave / arbiter: random grant latency, random wait states, and a
  // two-cycle ERROR response on the data phase of beat err_beat_cur.
  initial begin : slave
    int acc, req_cycles, gdelay, err_phase;
    logic last_hready;
    logic [1:0] last_trans;
    acc = 0; req_cycles = 0; gdelay = 0; err_phase = 0;
    last_hready = 1'b1; last_trans = 2'b00;
    hgrant_i = 1'b0; hready_i = 1'b1; hresp_i = 2'b00; hrdata_i = '0;
    forever begin
      @(negedge H_clk);
      if (!H_resetn) begin
        acc = 0; req_cycles = 0; err_phase = 0;
        last_hready = 1'b1; last_trans = 2'b00;
        hgrant_i = 1'b0; hready_i = 1'b1; hresp_i = 2'b00;
      end else begin
        if (cmd_ready_o) acc = 0;
        if (last_hready && last_trans != 2'b00) begin
          if (acc == err_beat_cur) err_phase = 2;
          acc++;
        end
        if (req_o) req_cycles++;
        else begin
          req_cycles = 0;
          gdelay = $urandom_range(0, 3);
        end
        hgrant_i = req_o && (req_cycles > gdelay);
        hrdata_i = $urandom;
        if (err_phase == 2) begin
          hready_i = 1'b0; hresp_i = 2'b01; err_phase = 1;
        end else if (err_phase == 1) begin
          hready_i = 1'b1; hresp_i = 2'b01; err_phase = 0;
        end else begin
          hready_i = ($urandom_range(0, 9) < 7); hresp_i = 2'b00;
        end
        last_hready = hready_i;
        last_trans  = trans_o;
      end
    end
  end

  // Monitor: tracks AHB phases from the bus signals and pops the scoreboard.
  initial begin : monitor
    logic dp_active, dp_write;
    dp_active = 1'b0; dp_write = 1'b0;
    forever begin
      @(negedge H_clk);
      #1;
      if (!H_resetn) begin
        check("reset_outputs", 128'({cmd_ready_o, req_o, lock_o, write_o, addr_o, wdata_o,
                                     burst_o, trans_o, rdata_o, rvalid_o, done_o, err_o}), 128'd0);
        aq.delete(); wq.delete(); rdq.delete(); dq.delete();
        dp_active = 1'b0;
      end else begin
        if (rvalid_o) begin
          if (rdq.size() == 0) timeout_fail("rvalid_unexpected");
          else check("rdata", 128'(rdata_o), 128'(rdq.pop_front()));
        end
        if (done_o) begin
          if (dq.size() == 0) timeout_fail("done_unexpected");
          else check("done_status", 128'({err_o, cmd_ready_o, req_o, lock_o, trans_o}),
                     128'({dq.pop_front(), 1'b1, 1'b0, 1'b0, 2'b00}));
        end
        if (hready_i) begin
          if (dp_active) begin
            if (dp_write) begin
              if (wq.size() == 0) timeout_fail("wdata_unexpected");
              else check("wdata", 128'(wdata_o), 128'(wq.pop_front()));
            end else begin
              rdq.push_back(hrdata_i);
            end
            dp_active = 1'b0;
          end
          if (trans_o != 2'b00) begin
            if (aq.size() == 0) timeout_fail("addr_unexpected");
            else check("addr_phase", 128'({trans_o, write_o, burst_o, addr_o, lock_o, req_o}),
                       128'(aq.pop_front()));
            dp_active = 1'b1;
            dp_write  = write_o;
          end
        end
      end
    end
  end

  // Reference model: a command expands into its beat list from the burst
  // rules; an ERROR on beat k truncates the list to k+1 beats when aborting.
  task automatic issue(input logic wr, input logic [2:0] burst, input logic [31:0] addr,
                       input logic [127:0] wd, input logic lock, input int eb);
    int beats, issued;
    logic [1:0] tr;
    logic [2:0] bu;
    bit ok;
    beats  = (burst == 3'b011) ? 4 : 1;
    bu     = (beats == 4) ? 3'b011 : 3'b000;
    issued = beats;
`ifdef AHB_MASTER_ERR_ABORT_EN
    if (eb >= 0) issued = eb + 1;
`endif
    for (int i = 0; i < issued; i++) begin
      tr = (i == 0) ? 2'b10 : 2'b11;
      aq.push_back({tr, wr, bu, addr + 32'(4 * i), lock, 1'b1});
      if (wr) wq.push_back(wd[32*i +: 32]);
    end
    dq.push_back(eb >= 0);
    err_beat_cur = eb;
    cmd_write_i = wr; cmd_burst_i = burst; cmd_addr_i = addr;
    cmd_wdata_i = wd; cmd_lock_i = lock; cmd_valid_i = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (cmd_ready_o) begin ok = 1'b1; break; end
      @(negedge H_clk);
    end
    if (!ok) timeout_fail("cmd_accept");
    @(posedge H_clk);
    @(negedge H_clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge H_clk);
      if (done_o) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail("done_wait");
  endtask

  task automatic run(input logic wr, input logic [2:0] burst, input logic [31:0] addr,
                     input logic [127:0] wd, input logic lock, input int eb);
    issue(wr, burst, addr, wd, lock, eb);
    wait_done();
    repeat ($urandom_range(0, 2)) @(negedge H_clk);
  endtask

  initial begin : stimulus
    logic [2:0]  bu;
    logic [127:0] wd;
    int eb;
    bit found;
    #1 H_resetn = 1'b0;
    repeat (3) @(posedge H_clk);
    #2 H_resetn = 1'b1;
    @(negedge H_clk);

    run(1'b1, 3'b000, 32'h1000_0000, {96'd0, 32'h0000_FFF1}, 1'b0, -1);
    run(1'b0, 3'b000, 32'h1000_0001, 128'd0, 1'b0, -1);
    run(1'b1, 3'b011, 32'h2000_0010, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1, -1);
    run(1'b0, 3'b011, 32'h3000_0040, 128'd0, 1'b0, -1);
    run(1'b1, 3'b011, 32'h4000_0000, {32'hD4, 32'hD3, 32'hD2, 32'hD1}, 1'b0, 0);
    run(1'b0, 3'b011, 32'h5000_0100, 128'd0, 1'b1, 2);
    run(1'b0, 3'b011, 32'hFFFF_FFF8, 128'd0, 1'b0, -1);
    run(1'b1, 3'b111, 32'h6000_0004, {96'd0, 32'hCAFE_0007}, 1'b0, -1);
    run(1'b1, 3'b000, 32'h6000_0008, {96'd0, 32'hBAD0_0001}, 1'b0, 0);

    // Reset in the middle of an INCR4 read, while beat 2 is on the bus.
    issue(1'b0, 3'b011, 32'h7000_0000, 128'd0, 1'b0, -1);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge H_clk);
      if (trans_o == 2'b11 && addr_o == 32'h7000_0008) begin found = 1'b1; break; end
    end
    if (!found) timeout_fail("reset_point");
    @(posedge H_clk);
    #2 H_resetn = 1'b0;
    repeat (3) @(negedge H_clk);
    @(posedge H_clk);
    #2 H_resetn = 1'b1;
    @(posedge H_clk);
    @(negedge H_clk);
    check("ready_after_reset", 128'(cmd_ready_o), 128'd1);
    run(1'b1, 3'b000, 32'h7000_0100, {96'd0, 32'h1234_5678}, 1'b0, -1);

    for (int k = 0; k < 40; k++) begin
      bu = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'($urandom_range(0, 7));
      wd = {$urandom, $urandom, $urandom, $urandom};
      eb = -1;
      if ($urandom_range(0, 3) == 0) eb = $urandom_range(0, (bu == 3'b011) ? 3 : 0);
      run(1'($urandom_range(0, 1)), bu, $urandom, wd, 1'($urandom_range(0, 1)), eb);
    end

    repeat (5) @(negedge H_clk);
    check("addr_queue_empty", 128'(aq.size()), 128'd0);
    check("wdata_queue_empty", 128'(wq.size()), 128'd0);
    check("rdata_queue_empty", 128'(rdq.size()), 128'd0);
    check("done_queue_empty", 128'(dq.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
